// File: rtl/digit_serial_adder_if.sv
// Handshake bundle for digit_serial_adder: operand channel in, result channel out.
// ovf exists only when DIGIT_SERIAL_ADDER_OVF_EN is defined.
interface digit_serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: WIDTH-bit operands processed DIGIT bits per clock with a
// registered inter-digit carry. Optional signed-overflow output via DIGIT_SERIAL_ADDER_OVF_EN.
module digit_serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    digit_serial_adder_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("digit_serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bx_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             out_valid_q;
    logic [IW-1:0]    base;
    logic [DIGIT:0]   dsum;

    assign base = IW'(int'(cnt) * DIGIT);

    always_comb begin
        dsum = {1'b0, a_q[base +: DIGIT]} + {1'b0, bx_q[base +: DIGIT]} + (DIGIT+1)'(carry);
    end

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic ovf_q;
    // On the final digit the MSB of the operands is the MSB of the word, so the
    // carry into it is recovered from a ^ b ^ s at that bit.
    logic cin_msb;
    assign cin_msb  = a_q[WIDTH-1] ^ bx_q[WIDTH-1] ^ dsum[DIGIT-1];
    assign bus.ovf  = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            carry       <= 1'b0;
            a_q         <= '0;
            bx_q        <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        bx_q  <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_q[base +: DIGIT] <= dsum[DIGIT-1:0];
                    carry                <= dsum[DIGIT];
                    if (cnt == CW'(NDIG - 1)) begin
                        cout_q      <= dsum[DIGIT];
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                        ovf_q       <= cin_msb ^ dsum[DIGIT];
`endif
                        cnt         <= '0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: DIGIT=8 and DIGIT=32 instances on one clock.
// Checks ovf as well when DIGIT_SERIAL_ADDER_OVF_EN is defined.
module tb_digit_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    digit_serial_adder_if #(.WIDTH(32)) bus8 ();
    digit_serial_adder_if #(.WIDTH(32)) bus32 ();

    digit_serial_adder #(.WIDTH(32), .DIGIT(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    digit_serial_adder #(.WIDTH(32), .DIGIT(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    task automatic drive_in(input bit w32, input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic s);
        if (w32) begin
            bus32.in_valid = v; bus32.a = a; bus32.b = b; bus32.sub = s;
        end else begin
            bus8.in_valid = v; bus8.a = a; bus8.b = b; bus8.sub = s;
        end
    endtask

    function automatic logic get_ov(input bit w32);
        return w32 ? bus32.out_valid : bus8.out_valid;
    endfunction

    // Presents one operation, returns edges from accept to out_valid (-1 on timeout).
    // Leaves the block in DONE with out_ready low; caller is at a negedge.
    task automatic start_op(input bit w32, input logic [31:0] a, input logic [31:0] b,
                            input logic s, output int lat);
        @(negedge clk);
        drive_in(w32, 1'b1, a, b, s);
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        drive_in(w32, 1'b0, a, b, s);
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!get_ov(w32) && lat < 50);
        if (!get_ov(w32)) lat = -1;
    endtask

    task automatic release_op(input bit w32);
        if (w32) bus32.out_ready = 1'b1; else bus8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (w32) bus32.out_ready = 1'b0; else bus8.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        n_cmp += 3;
        if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b expected 0", bus8.out_valid); end
        if (bus8.sum !== 32'h0) begin n_bad++; $display("FAIL rst_sum: got %h expected 00000000", bus8.sum); end
        if (bus8.cout !== 1'b0) begin n_bad++; $display("FAIL rst_cout: got %b expected 0", bus8.cout); end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        n_cmp++;
        if (bus8.ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b expected 0", bus8.ovf); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp += 2;
        if (bus8.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready8: got %b expected 1", bus8.in_ready); end
        if (bus32.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready32: got %b expected 1", bus32.in_ready); end
    endtask

    task automatic test_add;
        int lat;
        start_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, lat);
        n_cmp += 3;
        if (lat !== 4) begin n_bad++; $display("FAIL add_wrap_latency: got %0d expected 4", lat); end
        if (bus8.sum !== 32'h00000000) begin n_bad++; $display("FAIL add_wrap_sum: got %h expected 00000000", bus8.sum); end
        if (bus8.cout !== 1'b1) begin n_bad++; $display("FAIL add_wrap_cout: got %b expected 1", bus8.cout); end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        n_cmp++;
        if (bus8.ovf !== 1'b0) begin n_bad++; $display("FAIL add_wrap_ovf: got %b expected 0", bus8.ovf); end
`endif
        release_op(1'b0);
        n_cmp += 2;
        if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL handoff_out_valid: got %b expected 0", bus8.out_valid); end
        if (bus8.in_ready !== 1'b1) begin n_bad++; $display("FAIL handoff_in_ready: got %b expected 1", bus8.in_ready); end

        start_op(1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b0, lat);
        n_cmp += 2;
        if (bus8.sum !== 32'hACF13568) begin n_bad++; $display("FAIL add_mixed_sum: got %h expected acf13568", bus8.sum); end
        if (bus8.cout !== 1'b0) begin n_bad++; $display("FAIL add_mixed_cout: got %b expected 0", bus8.cout); end
        release_op(1'b0);
    endtask

    task automatic test_sub;
        int lat;
        start_op(1'b0, 32'd5, 32'd7, 1'b1, lat);
        n_cmp += 3;
        if (lat !== 4) begin n_bad++; $display("FAIL sub_neg_latency: got %0d expected 4", lat); end
        if (bus8.sum !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL sub_neg_sum: got %h expected fffffffe", bus8.sum); end
        if (bus8.cout !== 1'b0) begin n_bad++; $display("FAIL sub_neg_cout: got %b expected 0", bus8.cout); end
        release_op(1'b0);
        start_op(1'b0, 32'd7, 32'd5, 1'b1, lat);
        n_cmp += 2;
        if (bus8.sum !== 32'h00000002) begin n_bad++; $display("FAIL sub_pos_sum: got %h expected 00000002", bus8.sum); end
        if (bus8.cout !== 1'b1) begin n_bad++; $display("FAIL sub_pos_cout: got %b expected 1", bus8.cout); end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        n_cmp++;
        if (bus8.ovf !== 1'b0) begin n_bad++; $display("FAIL sub_pos_ovf: got %b expected 0", bus8.ovf); end
`endif
        release_op(1'b0);
    endtask

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    task automatic test_ovf;
        int lat;
        start_op(1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
        n_cmp += 3;
        if (bus8.sum !== 32'h80000000) begin n_bad++; $display("FAIL ovf_add_sum: got %h expected 80000000", bus8.sum); end
        if (bus8.cout !== 1'b0) begin n_bad++; $display("FAIL ovf_add_cout: got %b expected 0", bus8.cout); end
        if (bus8.ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_add_ovf: got %b expected 1", bus8.ovf); end
        release_op(1'b0);
        start_op(1'b0, 32'h80000000, 32'h00000001, 1'b1, lat);
        n_cmp += 3;
        if (bus8.sum !== 32'h7FFFFFFF) begin n_bad++; $display("FAIL ovf_sub_sum: got %h expected 7fffffff", bus8.sum); end
        if (bus8.cout !== 1'b1) begin n_bad++; $display("FAIL ovf_sub_cout: got %b expected 1", bus8.cout); end
        if (bus8.ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sub_ovf: got %b expected 1", bus8.ovf); end
        release_op(1'b0);
    endtask
`endif

    task automatic test_backpressure;
        int lat;
        start_op(1'b0, 32'h00000010, 32'h00000020, 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus8.in_valid = i[0];
            bus8.a = 32'hDEAD0000 + i;
            n_cmp += 4;
            if (bus8.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, bus8.out_valid); end
            if (bus8.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus8.in_ready); end
            if (bus8.sum !== 32'h00000030) begin n_bad++; $display("FAIL bp_sum[%0d]: got %h expected 00000030", i, bus8.sum); end
            if (bus8.cout !== 1'b0) begin n_bad++; $display("FAIL bp_cout[%0d]: got %b expected 0", i, bus8.cout); end
        end
        bus8.in_valid = 1'b0;
        release_op(1'b0);
        n_cmp += 2;
        if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b expected 0", bus8.out_valid); end
        if (bus8.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b expected 1", bus8.in_ready); end
    endtask

    task automatic test_reset_mid_run;
        int lat;
        @(negedge clk);
        drive_in(1'b0, 1'b1, 32'h11111111, 32'h11111111, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp += 4;
        if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_out_valid: got %b expected 0", bus8.out_valid); end
        if (bus8.sum !== 32'h0) begin n_bad++; $display("FAIL abort_sum: got %h expected 00000000", bus8.sum); end
        if (bus8.cout !== 1'b0) begin n_bad++; $display("FAIL abort_cout: got %b expected 0", bus8.cout); end
        if (bus8.in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_in_ready: got %b expected 1", bus8.in_ready); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(1'b0, 32'd3, 32'd4, 1'b0, lat);
        n_cmp += 3;
        if (lat !== 4) begin n_bad++; $display("FAIL post_abort_latency: got %0d expected 4", lat); end
        if (bus8.sum !== 32'd7) begin n_bad++; $display("FAIL post_abort_sum: got %h expected 00000007", bus8.sum); end
        if (bus8.cout !== 1'b0) begin n_bad++; $display("FAIL post_abort_cout: got %b expected 0", bus8.cout); end
        release_op(1'b0);
    endtask

    task automatic test_digit32;
        int lat;
        start_op(1'b1, 32'h12345678, 32'h11111111, 1'b0, lat);
        n_cmp += 3;
        if (lat !== 1) begin n_bad++; $display("FAIL d32_latency: got %0d expected 1", lat); end
        if (bus32.sum !== 32'h23456789) begin n_bad++; $display("FAIL d32_sum: got %h expected 23456789", bus32.sum); end
        if (bus32.cout !== 1'b0) begin n_bad++; $display("FAIL d32_cout: got %b expected 0", bus32.cout); end
        release_op(1'b1);
    endtask

    task automatic test_back_to_back;
        localparam int N = 10;
        logic [31:0] va [N];
        logic [31:0] vb [N];
        logic        vs [N];
        logic [32:0] exp_q[$];
        logic [32:0] e;
        int issued = 0;
        int got = 0;
        va[0] = 32'hFFFFFFFF; vb[0] = 32'h00000001; vs[0] = 1'b0;
        va[1] = 32'h00000000; vb[1] = 32'h00000001; vs[1] = 1'b1;
        va[2] = 32'h80000000; vb[2] = 32'h80000000; vs[2] = 1'b0;
        va[3] = 32'h00000000; vb[3] = 32'h00000000; vs[3] = 1'b1;
        for (int i = 4; i < N; i++) begin
            va[i] = $urandom; vb[i] = $urandom; vs[i] = 1'($urandom_range(1, 0));
        end
        bus32.out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && got < N; cyc++) begin
            @(negedge clk);
            if (bus32.out_valid) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({bus32.cout, bus32.sum} !== e) begin
                    n_bad++;
                    $display("FAIL b2b[%0d]: got cout=%b sum=%h expected cout=%b sum=%h",
                             got, bus32.cout, bus32.sum, e[32], e[31:0]);
                end
                got++;
            end
            if (bus32.in_ready && issued < N) begin
                drive_in(1'b1, 1'b1, va[issued], vb[issued], vs[issued]);
                exp_q.push_back({1'b0, va[issued]} + {1'b0, vs[issued] ? ~vb[issued] : vb[issued]}
                                + {32'd0, vs[issued]});
                issued++;
            end else if (bus32.in_ready) begin
                bus32.in_valid = 1'b0;
            end
        end
        n_cmp++;
        if (got !== N) begin n_bad++; $display("FAIL b2b_count: got %0d expected %0d", got, N); end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b0;
    endtask

    initial begin
        drive_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive_in(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        bus8.out_ready  = 1'b0;
        bus32.out_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        test_backpressure();
        test_reset_mid_run();
        test_digit32();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
Parametrised, multi-cycle successor to the flat 32-bit ripple adder used in the crypto benchmarks. Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, with a registered carry between digits, so datapath area scales with DIGIT rather than WIDTH. Operands arrive and results leave through valid/ready handshakes, so the block can sit between benchmark stimulus sources and checkers in clocked test harnesses.

Parameters:
WIDTH, 32, operand and sum width in bits; must be at least 1.
DIGIT, 8, bits processed per cycle; must be at least 1 and divide WIDTH exactly (elaboration error otherwise).
NDIG, WIDTH/DIGIT, derived local parameter giving the number of digit cycles per operation; not overridable.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0 computes a+b; 1 computes a-b
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result modulo 2^WIDTH
cout  output  1  carry out of the MSB; for sub, 1 means no borrow (a >= b unsigned)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, digit counter=0, carry=0, sum=0, cout=0, out_valid=0. in_ready is 1 once reset is released.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE), driven combinationally from the state register only. out_valid = (state==DONE), registered.
- IDLE: on in_valid && in_ready, latch a and (sub ? ~b : b); set carry=sub and counter=0; go to RUN. With in_valid low, stay in IDLE.
- RUN, one digit per cycle, k = counter: {c, s} = a[k*DIGIT +: DIGIT] + bx[k*DIGIT +: DIGIT] + carry. Write s into sum[k*DIGIT +: DIGIT], set carry=c, increment counter. On the cycle with counter==NDIG-1, set cout=c and go to DONE.
- Latency: out_valid rises exactly NDIG clock edges after the accepting edge. With DIGIT==WIDTH, that is 1 edge.
- DONE: sum and cout hold stable while out_ready is low, for an unbounded time. On out_ready high, go to IDLE at the next edge; out_valid falls on that edge.
- Throughput: one operation per NDIG+2 cycles (accept, NDIG digit cycles, hand-off). No overlap between operations.
- in_valid while not IDLE is ignored. a, b and sub are sampled only on the accepting edge; later changes have no effect on the operation in flight.
- sum bits not yet written during RUN are don't-care and must not be checked until out_valid is high.
- Reset asserted mid-RUN or in DONE aborts the operation immediately: all outputs return to reset values and no result is produced.
- Arithmetic is unsigned modulo 2^WIDTH. Subtraction is two's complement (invert B, carry-in 1).

Optional Feature:
Macro DIGIT_SERIAL_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit). ovf is the signed overflow flag: carry into the MSB XOR carry out of the MSB, captured on the final RUN cycle. It resets to 0 and holds alongside sum in DONE.
- Not defined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=32, DIGIT=8, a=0xFFFFFFFF, b=0x00000001, sub=0 -> out_valid 4 edges after accept; sum=0x00000000, cout=1; ovf=0 if enabled.
- a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0. Then a=7, b=5, sub=1 -> sum=0x00000002, cout=1.
- With DIGIT_SERIAL_ADDER_OVF_EN: a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, cout=0, ovf=1. Also a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1.
- Backpressure: hold out_ready low 10 cycles in DONE -> sum, cout and out_valid stable, in_ready=0. Toggle in_valid and change a during this window -> no effect on the held result.
- Drop rst_n during RUN cycle 2 -> out_valid=0, sum=0 asynchronously; after release, a new add 3+4 returns 7 with the correct latency.
- DIGIT=32 (NDIG=1): a=0x12345678, b=0x11111111 -> sum=0x23456789 one edge after accept. Back-to-back random operations with out_ready tied high match a reference model.
